// File: rtl/linear_layer_sequencer.sv
// Sequencer for a quantized linear layer y = W*x + b: walks SRAM operands through one
// pipelined Q5.10 MAC with a dependent accumulator chain and writes saturated results.
module linear_layer_sequencer #(
    parameter int WIDTH  = 16,
    parameter int ACC_W  = 2 * WIDTH,
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] x_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  x_rdata,
    input  logic [WIDTH-1:0]  w_rdata,
    input  logic [WIDTH-1:0]  b_rdata,
    output logic              mac_start,
    output logic [WIDTH-1:0]  mac_a,
    output logic [WIDTH-1:0]  mac_b,
    output logic [ACC_W-1:0]  mac_acc_in,
    input  logic [ACC_W-1:0]  mac_acc_out,
    input  logic              mac_valid,
    output logic              y_we,
    output logic [ADDR_W-1:0] y_addr,
    output logic [WIDTH-1:0]  y_wdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [DIM_W-1:0]        DIM_ONE  = DIM_W'(1);
    localparam logic [ADDR_W-1:0]       ADDR_ONE = ADDR_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    state_t                  state_r;
    logic [DIM_W-1:0]        rows_r;
    logic [DIM_W-1:0]        cols_r;
    logic [DIM_W-1:0]        row_r;
    logic [DIM_W-1:0]        col_r;
    logic [ADDR_W-1:0]       wptr_r;
    logic signed [ACC_W-1:0] acc_r;

    function automatic logic [WIDTH-1:0] sat16(input logic signed [ACC_W-1:0] a);
        logic [WIDTH-1:0] res;
        if (a > SAT_MAX) begin
            res = SAT_MAX[WIDTH-1:0];
        end else if (a < SAT_MIN) begin
            res = SAT_MIN[WIDTH-1:0];
        end else begin
            res = a[WIDTH-1:0];
        end
        return res;
    endfunction

    // Operand buses pass SRAM read data straight through in ISSUE (data arrives that cycle).
    always_comb begin
        mac_a      = {WIDTH{1'b0}};
        mac_b      = {WIDTH{1'b0}};
        mac_acc_in = {ACC_W{1'b0}};
        if (mac_start) begin
            mac_a = x_rdata;
            mac_b = w_rdata;
            if (col_r == {DIM_W{1'b0}}) begin
                mac_acc_in = {{(ACC_W-WIDTH){b_rdata[WIDTH-1]}}, b_rdata};
            end else begin
                mac_acc_in = acc_r;
            end
        end else begin
            mac_a      = {WIDTH{1'b0}};
            mac_b      = {WIDTH{1'b0}};
            mac_acc_in = {ACC_W{1'b0}};
        end
    end

    // Sequencer FSM; strobes and addresses are registered together with the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            rows_r    <= {DIM_W{1'b0}};
            cols_r    <= {DIM_W{1'b0}};
            row_r     <= {DIM_W{1'b0}};
            col_r     <= {DIM_W{1'b0}};
            wptr_r    <= {ADDR_W{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            x_addr    <= {ADDR_W{1'b0}};
            w_addr    <= {ADDR_W{1'b0}};
            b_addr    <= {ADDR_W{1'b0}};
            mac_start <= 1'b0;
            y_we      <= 1'b0;
            y_addr    <= {ADDR_W{1'b0}};
            y_wdata   <= {WIDTH{1'b0}};
        end else begin
            rd_en     <= 1'b0;
            x_addr    <= {ADDR_W{1'b0}};
            w_addr    <= {ADDR_W{1'b0}};
            b_addr    <= {ADDR_W{1'b0}};
            mac_start <= 1'b0;
            y_we      <= 1'b0;
            y_addr    <= {ADDR_W{1'b0}};
            y_wdata   <= {WIDTH{1'b0}};
            done      <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        rows_r <= cfg_rows;
                        cols_r <= cfg_cols;
                        row_r  <= {DIM_W{1'b0}};
                        col_r  <= {DIM_W{1'b0}};
                        wptr_r <= {ADDR_W{1'b0}};
                        if ((cfg_rows == {DIM_W{1'b0}}) || (cfg_cols == {DIM_W{1'b0}})) begin
                            state_r <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= S_FETCH;
                            busy    <= 1'b1;
                            rd_en   <= 1'b1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    state_r   <= S_ISSUE;
                    mac_start <= 1'b1;
                end
                S_ISSUE: begin
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (mac_valid) begin
                        acc_r  <= mac_acc_out;
                        wptr_r <= wptr_r + ADDR_ONE;
                        if (col_r < (cols_r - DIM_ONE)) begin
                            col_r   <= col_r + DIM_ONE;
                            state_r <= S_FETCH;
                            rd_en   <= 1'b1;
                            x_addr  <= ADDR_W'(col_r + DIM_ONE);
                            w_addr  <= wptr_r + ADDR_ONE;
                            b_addr  <= ADDR_W'(row_r);
                        end else begin
                            state_r <= S_WRITE;
                            y_we    <= 1'b1;
                            y_addr  <= ADDR_W'(row_r);
                            y_wdata <= sat16(mac_acc_out);
                        end
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_WRITE: begin
                    if (row_r < (rows_r - DIM_ONE)) begin
                        row_r   <= row_r + DIM_ONE;
                        col_r   <= {DIM_W{1'b0}};
                        state_r <= S_FETCH;
                        rd_en   <= 1'b1;
                        w_addr  <= wptr_r;
                        b_addr  <= ADDR_W'(row_r + DIM_ONE);
                    end else begin
                        state_r <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
